// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS7 (x^7 + x^6 + 1) checker.
package prbs_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int PRBS_LEN = 7;
  localparam int TAP_A    = 6;
  localparam int TAP_B    = 5;

endpackage

// File: rtl/prbs7_lfsr.sv
// Seven-bit pattern register. s[0] is the newest bit, s[6] the oldest.
// While searching, the received bit is shifted in so the register locks onto
// the incoming sequence; once locked, the prediction is shifted in instead so
// that a corrupted received bit never poisons later predictions.
module prbs7_lfsr
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load_sel,   // 0: shift in in_bit, 1: shift in prediction
  input  logic in_bit,
  output logic p,
  output logic s_zero
);

  logic [PRBS_LEN-1:0] s_q;
  logic [PRBS_LEN-1:0] s_d;

  assign p      = s_q[TAP_A] ^ s_q[TAP_B];
  assign s_zero = (s_q == '0);

  // Shift only on an accepted bit; idle cycles leave the register untouched.
  always_comb begin
    s_d = s_q;
    if (en) begin
      s_d = {s_q[PRBS_LEN-2:0], (load_sel ? p : in_bit)};
    end
  end

  // Pattern register flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

endmodule

// File: rtl/prbs7_checker.sv
// Serial PRBS7 checker: self-synchronises, then flags and counts bit errors.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   SEARCH | register loads received bits; waiting for LOCK_CNT straight hits
//   LOCKED | register free-runs; mismatches are flagged and counted,
//          | LOSS_CNT straight misses drop back to SEARCH
//
// Both run-length counters are down-counters reloaded with their terminal
// value; reaching 1 on a qualifying bit is the terminal event.
module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_clear,
  output logic             out_locked,
  output logic             out_err,
  output logic [CNT_W-1:0] out_err_count
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MS_W = $clog2(LOSS_CNT + 1);
  localparam logic [MC_W-1:0] LOCK_TC = MC_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] LOSS_TC = MS_W'(LOSS_CNT);

  state_e           state_q, state_d;
  logic [MC_W-1:0]  match_left_q, match_left_d;
  logic [MS_W-1:0]  miss_left_q, miss_left_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic p;
  logic s_zero;
  logic load_pred;

  assign load_pred = (state_q == LOCKED);

  prbs7_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (in_valid),
    .load_sel (load_pred),
    .in_bit   (in_bit),
    .p        (p),
    .s_zero   (s_zero)
  );

  // Next-state, run-length counters and error counter.
  always_comb begin
    state_d      = state_q;
    match_left_d = match_left_q;
    miss_left_d  = miss_left_q;
    err_d        = 1'b0;
    cnt_d        = cnt_q;

    if (in_valid) begin
      if (state_q == SEARCH) begin
        // An all-zero register predicts 0 forever, so it never counts as a hit.
        if ((in_bit == p) && !s_zero) begin
          if (match_left_q == MC_W'(1)) begin
            state_d      = LOCKED;
            match_left_d = LOCK_TC;
            miss_left_d  = LOSS_TC;
          end else begin
            match_left_d = match_left_q - 1'b1;
          end
        end else begin
          match_left_d = LOCK_TC;
        end
      end else begin
        if (in_bit != p) begin
          // The error that causes loss of lock is still reported.
          err_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (miss_left_q == MS_W'(1)) begin
            state_d      = SEARCH;
            match_left_d = LOCK_TC;
            miss_left_d  = LOSS_TC;
          end else begin
            miss_left_d = miss_left_q - 1'b1;
          end
        end else begin
          miss_left_d = LOSS_TC;
        end
      end
    end

    // Clear beats a same-cycle increment.
    if (in_clear) begin
      cnt_d = '0;
    end
  end

  // State and counter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      match_left_q <= LOCK_TC;
      miss_left_q  <= LOSS_TC;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      match_left_q <= match_left_d;
      miss_left_q  <= miss_left_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_locked    = (state_q == LOCKED);
  assign out_err       = err_q;
  assign out_err_count = cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two instances (16-bit and 4-bit error counters)
// share one stimulus stream and are compared every cycle against a
// sequence-level reference model.
module tb_prbs7_checker;

  localparam int LOCK = 16;
  localparam int LOSS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_clear = 1'b0;
  logic        locked16, err16, locked4, err4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  prbs7_checker u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_bit        (in_bit),
    .in_clear      (in_clear),
    .out_locked    (locked16),
    .out_err       (err16),
    .out_err_count (cnt16)
  );

  prbs7_checker #(.CNT_W(4)) u_dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_bit        (in_bit),
    .in_clear      (in_clear),
    .out_locked    (locked4),
    .out_err       (err4),
    .out_err_count (cnt4)
  );

  // One period of the PRBS7 sequence: b[n] = b[n-7] ^ b[n-6], seed all ones.
  bit pat[127];
  int pidx = 0;

  // Reference model: last seven register bits, oldest first.
  bit m_reg[$];
  bit m_locked;
  bit m_err;
  int m_cnt;
  int m_run;
  int m_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_reg.delete();
    repeat (7) m_reg.push_back(1'b0);
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
    m_run    = 0;
    m_miss   = 0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit pred;
    bit nz;
    m_err = 1'b0;
    if (v) begin
      pred = m_reg[0] ^ m_reg[1];
      nz = 1'b0;
      foreach (m_reg[i]) if (m_reg[i]) nz = 1'b1;
      void'(m_reg.pop_front());
      if (!m_locked) begin
        m_reg.push_back(b);
        if (b == pred && nz) m_run++;
        else m_run = 0;
        if (m_run == LOCK) begin
          m_locked = 1'b1;
          m_run = 0;
          m_miss = 0;
        end
      end else begin
        m_reg.push_back(pred);
        if (b != pred) begin
          m_err = 1'b1;
          m_cnt++;
          m_miss++;
        end else begin
          m_miss = 0;
        end
        if (m_miss == LOSS) begin
          m_locked = 1'b0;
          m_miss = 0;
          m_run = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
  endtask

  task automatic send(input bit v, input bit b, input bit clr);
    in_valid = v;
    in_bit   = b;
    in_clear = clr;
    @(posedge clk);
    model_step(v, b, clr);
    #1;
    check("locked16", locked16, m_locked);
    check("locked4", locked4, m_locked);
    check("err16", err16, m_err);
    check("err4", err4, m_err);
    check("cnt16", cnt16, sat(m_cnt, 65535));
    check("cnt4", cnt4, sat(m_cnt, 15));
  endtask

  task automatic send_pat(input bit flip, input bit clr);
    bit b;
    b = pat[pidx] ^ flip;
    pidx = (pidx + 1) % 127;
    send(1'b1, b, clr);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_clear = 1'b0;
    in_bit   = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #1;
    check("rst_locked", locked16, 0);
    check("rst_err", err16, 0);
    check("rst_cnt16", cnt16, 0);
    check("rst_cnt4", cnt4, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int lock_at;
    int relock_at;

    for (int n = 0; n < 7; n++) pat[n] = 1'b1;
    for (int n = 7; n < 127; n++) pat[n] = pat[n-7] ^ pat[n-6];

    #2;
    do_reset();

    // All ones never looks like PRBS7.
    repeat (40) send(1'b1, 1'b1, 1'b0);
    check("ones_no_lock", locked16, 0);

    // Clean stream: lock within 23 bits, hold for 500.
    do_reset();
    lock_at = 0;
    for (int i = 1; i <= 500; i++) begin
      send_pat(1'b0, 1'b0);
      if (locked16 && lock_at == 0) lock_at = i;
    end
    check("lock_by_23", (lock_at >= 1 && lock_at <= 23), 1);
    check("clean_locked", locked16, 1);
    check("clean_cnt", cnt16, 0);

    // Single inverted bit.
    send_pat(1'b1, 1'b0);
    check("single_err", err16, 1);
    check("single_cnt", cnt16, 1);
    repeat (20) send_pat(1'b0, 1'b0);
    check("single_hold", locked16, 1);
    check("single_cnt_after", cnt16, 1);

    // Four consecutive errors drop lock on the fourth pulse, then relock.
    repeat (3) send_pat(1'b1, 1'b0);
    check("loss3_locked", locked16, 1);
    send_pat(1'b1, 1'b0);
    check("loss4_err", err16, 1);
    check("loss4_locked", locked16, 0);
    check("loss4_cnt", cnt16, 5);
    relock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      send_pat(1'b0, 1'b0);
      if (locked16 && relock_at == 0) relock_at = i;
    end
    check("relock_by_23", (relock_at >= 1 && relock_at <= 23), 1);

    // Clear on an idle cycle.
    send(1'b0, 1'b0, 1'b1);
    check("idle_clear", cnt16, 0);

    // Every other bit wrong: lock holds, 4-bit counter saturates.
    for (int i = 0; i < 40; i++) send_pat(i[0], 1'b0);
    check("alt_locked", locked4, 1);
    check("alt_sat4", cnt4, 15);
    check("alt_cnt16", cnt16, 20);

    // Clear coincident with an error wins.
    send_pat(1'b1, 1'b1);
    check("clr_err_pulse", err16, 1);
    check("clr_win16", cnt16, 0);
    check("clr_win4", cnt4, 0);

    // Mid-stream reset while locked with a nonzero count.
    send_pat(1'b0, 1'b0);
    send_pat(1'b1, 1'b0);
    do_reset();

    // Random valid gaps on a clean stream.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) send_pat(1'b0, 1'b0);
      else send(1'b0, $urandom_range(0, 1) == 1, 1'b0);
    end
    check("gap_locked", locked16, 1);
    check("gap_cnt", cnt16, 0);

    // Random gaps, sparse errors and occasional clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0)
        send_pat($urandom_range(0, 14) == 0, $urandom_range(0, 49) == 0);
      else
        send(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
